adc_capture: RTL

Receive-side counterpart of the DAC playback chain: registers parallel ADC samples and decimates them by 2^DS_PARAM with boxcar averaging. Buffers a fixed-length capture of decimated words in an internal FIFO and exposes them to the downstream consumer through a read-enable interface. It sits between the ADC pins and the host/processing logic that drains capture data.

---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_sample_fifo.sv | 86 ++++++++
 rtl/adc_capture.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC capture path: FSM states,
// parameter range limits and accumulator sizing.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DATAWIDTH_MIN = 1;
    localparam int DATAWIDTH_MAX = 32;
    localparam int DS_PARAM_MIN  = 0;
    localparam int DS_PARAM_MAX  = 8;

    // Summing 2^ds samples of dw bits needs ds extra bits to never wrap.
    function automatic int acc_width(input int dw, input int ds);
        return dw + ds;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous single-clock FIFO with registered read data and registered
// empty/full/count flags that move on the same edge as the pointers.
module adc_sample_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [WIDTH-1:0]       wr_data_i,
    input  logic                   rd_en_i,
    output logic [WIDTH-1:0]       rd_data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_fire, rd_fire;

    // A full FIFO still accepts a write when a pop happens on the same edge.
    assign wr_fire = wr_en_i && (!full_q || rd_en_i);
    assign rd_fire = rd_en_i && !empty_q;
    assign drop_o  = wr_en_i && !wr_fire;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        count_d   = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign empty_o   = empty_q;
    assign full_o    = full_q;
    assign count_o   = count_q;

endmodule

// File: rtl/adc_capture.sv
// ADC capture: input register, 2^DS_PARAM boxcar decimator, fixed-length
// capture FSM and an output FIFO drained by the consumer via rd_en.
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATAWIDTH  = 14,
    parameter int DS_PARAM   = 4,
    parameter int FIFO_DEPTH = 64,
    parameter int CAP_LEN    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATAWIDTH-1:0]        adc_data,
    input  logic                        adc_or,
    input  logic                        rd_en,
    output logic [DATAWIDTH-1:0]        rd_data,
    output logic                        fifo_empty,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic                        over_range,
    output state_t                      dbg_state
);

    localparam int ACC_W = acc_width(DATAWIDTH, DS_PARAM);
    localparam int PH_W  = (DS_PARAM == 0) ? 1 : DS_PARAM;
    localparam int WC_W  = $clog2(CAP_LEN + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DS_PARAM) - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(CAP_LEN - 1);

    state_t           state_q, state_d;
    logic [DATAWIDTH-1:0] s_data_q;
    logic             s_or_q;
    logic             s_valid_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             overflow_q, overflow_d;
    logic             over_range_q, over_range_d;

    logic [ACC_W-1:0]     sum;
    logic [DATAWIDTH-1:0] word;
    logic                 capturing;
    logic                 word_valid;
    logic                 fifo_drop;

    // s_valid_q marks s_data_q as a sample taken after start was accepted,
    // so the pre-capture sample in the input register is never accumulated.
    assign capturing  = (state_q == CAPTURE) && s_valid_q;
    assign word_valid = capturing && (phase_q == PH_LAST);
    assign sum        = (phase_q == '0) ? ACC_W'(s_data_q) : acc_q + ACC_W'(s_data_q);
    assign word       = DATAWIDTH'(sum >> DS_PARAM);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        phase_d      = phase_q;
        wcnt_d       = wcnt_q;
        overflow_d   = overflow_q;
        over_range_d = over_range_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = CAPTURE;
                    acc_d        = '0;
                    phase_d      = '0;
                    wcnt_d       = '0;
                    overflow_d   = 1'b0;
                    over_range_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (s_or_q) begin
                    over_range_d = 1'b1;
                end
                if (capturing) begin
                    acc_d   = sum;
                    phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                end
                if (word_valid) begin
                    if (fifo_drop) begin
                        overflow_d = 1'b1;
                    end
                    wcnt_d = wcnt_q + WC_W'(1);
                    if (wcnt_q == WC_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            s_data_q     <= '0;
            s_or_q       <= 1'b0;
            s_valid_q    <= 1'b0;
            acc_q        <= '0;
            phase_q      <= '0;
            wcnt_q       <= '0;
            overflow_q   <= 1'b0;
            over_range_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_data_q     <= adc_data;
            s_or_q       <= adc_or;
            s_valid_q    <= (state_q == CAPTURE);
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            wcnt_q       <= wcnt_d;
            overflow_q   <= overflow_d;
            over_range_q <= over_range_d;
        end
    end

    // Consumer side: rd_en with fifo_empty=0 pops one word, visible on
    // rd_data after that edge; rd_en while empty is ignored.
    adc_sample_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (word_valid),
        .wr_data_i (word),
        .rd_en_i   (rd_en),
        .rd_data_o (rd_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .count_o   (fifo_count),
        .drop_o    (fifo_drop)
    );

    assign busy       = (state_q == CAPTURE);
    assign done       = (state_q == DONE);
    assign overflow   = overflow_q;
    assign over_range = over_range_q;
    assign dbg_state  = state_q;

endmodule
